// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//
// Iterative multiply/divide unit that owns the architectural HI/LO registers
// of the pipelined MIPS core. It runs MULT/MULTU as a 32-step shift-add and
// DIV/DIVU as a 32-step restoring divide over magnitudes. A final FIX cycle
// applies the sign correction and writes HI/LO. MTHI/MTLO write HI/LO
// directly from IDLE in a single edge.
//
// Ports:
//   clk     in   system clock, all state changes on the rising edge
//   reset   in   synchronous active-high reset (aborts any in-flight op)
//   start   in   EX-stage mul/div-class instruction valid this cycle
//   op      in   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//                11x reserved (ignored)
//   rs_val  in   forwarded rs operand (multiplicand / dividend / MT source)
//   rt_val  in   forwarded rt operand (multiplier / divisor)
//   mf_req  in   MFHI/MFLO present in the ID stage
//   busy    out  operation in flight (RUN or FIX)
//   stall   out  stall request to the hazard unit (busy & (start | mf_req))
//   done    out  one-cycle pulse after HI/LO were written by MULT/DIV
//   hi, lo  out  architectural HI/LO registers
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mf_req,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t               state_reg,    state_next;
    logic [CNT_W-1:0]     cnt_reg,      cnt_next;
    // Shared working register:
    //   multiply: {partial product upper half, remaining multiplier bits}
    //   divide:   {partial remainder, dividend bits shifting into quotient}
    logic [2*WIDTH-1:0]   acc_reg,      acc_next;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide).
    logic [WIDTH-1:0]     b_reg,        b_next;
    // Raw rs value, returned as HI on divide by zero.
    logic [WIDTH-1:0]     rs_raw_reg,   rs_raw_next;
    logic                 sign_a_reg,   sign_a_next;
    logic                 sign_b_reg,   sign_b_next;
    logic                 is_div_reg,   is_div_next;
    logic                 div_zero_reg, div_zero_next;
    logic [WIDTH-1:0]     hi_reg,       hi_next;
    logic [WIDTH-1:0]     lo_reg,       lo_next;
    logic                 done_reg,     done_next;

    // -----------------------------------------------------------------------
    // Operand decode for the launch edge
    // -----------------------------------------------------------------------
    logic             op_is_muldiv;
    logic             op_is_div;
    logic             op_signed;
    logic             sign_a_in;
    logic             sign_b_in;
    logic [WIDTH-1:0] abs_a_in;
    logic [WIDTH-1:0] abs_b_in;

    assign op_is_muldiv = ~op[2];
    assign op_is_div    = op[1];
    assign op_signed    = ~op[0];
    // Unsigned ops treat both operands as non-negative magnitudes.
    assign sign_a_in    = op_signed & rs_val[WIDTH-1];
    assign sign_b_in    = op_signed & rt_val[WIDTH-1];
    // -0x80000000 wraps to 0x80000000, which is the correct unsigned
    // magnitude 2^31, so no special case is needed for the most negative value.
    assign abs_a_in     = sign_a_in ? (-rs_val) : rs_val;
    assign abs_b_in     = sign_b_in ? (-rt_val) : rt_val;

    // -----------------------------------------------------------------------
    // One multiply iteration: conditional add into the upper half, keeping
    // the carry so the right shift brings it back in as the new MSB.
    // -----------------------------------------------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     mul_upper;
    logic [2*WIDTH-1:0] mul_step;

    assign mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, b_reg};
    assign mul_upper = acc_reg[0] ? mul_sum : {1'b0, acc_reg[2*WIDTH-1:WIDTH]};
    assign mul_step  = {mul_upper, acc_reg[WIDTH-1:1]};

    // -----------------------------------------------------------------------
    // One restoring-divide iteration. The shifted remainder needs WIDTH+1
    // bits because the previous remainder can be as large as divisor-1, which
    // may already use the top bit. After a successful subtract the result is
    // below the divisor, so WIDTH bits always hold the new remainder.
    // -----------------------------------------------------------------------
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_step;

    assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, b_reg});
    assign div_diff  = div_shift[WIDTH-1:0] - b_reg;
    assign div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
    assign div_step  = {div_rem, acc_reg[WIDTH-2:0], div_ge};

    // -----------------------------------------------------------------------
    // Sign correction applied in FIX
    // -----------------------------------------------------------------------
    logic               neg_result;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_raw;
    logic [WIDTH-1:0]   rem_raw;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign neg_result = sign_a_reg ^ sign_b_reg;
    assign prod_fix   = neg_result ? (-acc_reg) : acc_reg;
    assign quot_raw   = acc_reg[WIDTH-1:0];
    assign rem_raw    = acc_reg[2*WIDTH-1:WIDTH];
    assign quot_fix   = neg_result ? (-quot_raw) : quot_raw;
    // The remainder follows the dividend's sign (truncating division).
    assign rem_fix    = sign_a_reg ? (-rem_raw) : rem_raw;

    // -----------------------------------------------------------------------
    // Next-state / datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        acc_next      = acc_reg;
        b_next        = b_reg;
        rs_raw_next   = rs_raw_reg;
        sign_a_next   = sign_a_reg;
        sign_b_next   = sign_b_reg;
        is_div_next   = is_div_reg;
        div_zero_next = div_zero_reg;
        hi_next       = hi_reg;
        lo_next       = lo_reg;
        done_next     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (op_is_muldiv) begin
                        state_next    = ST_RUN;
                        cnt_next      = '0;
                        rs_raw_next   = rs_val;
                        sign_a_next   = sign_a_in;
                        sign_b_next   = sign_b_in;
                        is_div_next   = op_is_div;
                        div_zero_next = op_is_div & (rt_val == '0);
                        if (op_is_div) begin
                            // Remainder starts at zero, dividend shifts in.
                            acc_next = {{WIDTH{1'b0}}, abs_a_in};
                            b_next   = abs_b_in;
                        end else begin
                            // Upper half accumulates, multiplier shifts out.
                            acc_next = {{WIDTH{1'b0}}, abs_b_in};
                            b_next   = abs_a_in;
                        end
                    end else if (op == OP_MTHI) begin
                        hi_next = rs_val;
                    end else if (op == OP_MTLO) begin
                        lo_next = rs_val;
                    end
                end
            end

            ST_RUN: begin
                acc_next = is_div_reg ? div_step : mul_step;
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_FIX;
                end
            end

            ST_FIX: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                done_next  = 1'b1;
                if (!is_div_reg) begin
                    hi_next = prod_fix[2*WIDTH-1:WIDTH];
                    lo_next = prod_fix[WIDTH-1:0];
                end else if (div_zero_reg) begin
                    // The iterations still ran but their result is discarded.
                    hi_next = rs_raw_reg;
                    lo_next = {WIDTH{1'b1}};
                end else begin
                    hi_next = rem_fix;
                    lo_next = quot_fix;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            acc_reg      <= '0;
            b_reg        <= '0;
            rs_raw_reg   <= '0;
            sign_a_reg   <= 1'b0;
            sign_b_reg   <= 1'b0;
            is_div_reg   <= 1'b0;
            div_zero_reg <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            acc_reg      <= acc_next;
            b_reg        <= b_next;
            rs_raw_reg   <= rs_raw_next;
            sign_a_reg   <= sign_a_next;
            sign_b_reg   <= sign_b_next;
            is_div_reg   <= is_div_next;
            div_zero_reg <= div_zero_next;
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
            done_reg     <= done_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign busy  = (state_reg != ST_IDLE);
    // While idle the unit never stalls: HI/LO are registers, so an MF in the
    // done cycle already sees the final result.
    assign stall = busy & (start | mf_req);
    assign done  = done_reg;
    assign hi    = hi_reg;
    assign lo    = lo_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Directed and randomized checks of muldiv_sequencer. Expected HI/LO values
// come from plain 64-bit arithmetic (signed/unsigned multiply, truncating
// divide and modulo) plus the divide-by-zero rule.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mf_req;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    muldiv_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .mf_req (mf_req),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result {hi, lo} from ordinary arithmetic.
    function automatic logic [63:0] ref_hilo(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] res;
        sa = longint'({{32{a[31]}}, a});
        sb = longint'({{32{b[31]}}, b});
        res = '0;
        case (o)
            3'b000: res = sa * sb;
            3'b001: res = {32'd0, a} * {32'd0, b};
            3'b010: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFFFFFF};
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFFFFFF};
                else            res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // Launch one mul/div, optionally scramble inputs while busy, and check
    // latency, stall behaviour, the done pulse and the final HI/LO.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_hilo, input bit noisy);
        int busy_cnt;
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        mf_req = 1'($urandom_range(0, 1));
        #1;
        check("launch_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        start    = 1'b0;
        mf_req   = 1'b0;
        busy_cnt = 0;
        while (busy === 1'b1 && busy_cnt < 100) begin
            busy_cnt++;
            if (noisy) begin
                rs_val = $urandom;
                rt_val = $urandom;
                mf_req = 1'($urandom_range(0, 1));
                start  = 1'($urandom_range(0, 1));
                op     = 3'b011;
                #1;
                check("busy_stall", {63'd0, stall}, {63'd0, (mf_req | start)});
            end
            @(negedge clk);
        end
        start  = 1'b0;
        op     = 3'b000;
        mf_req = 1'b1;
        #1;
        check("busy_cycles", 64'(busy_cnt), 64'd33);
        check("done_pulse", {63'd0, done}, 64'd1);
        check("done_stall", {63'd0, stall}, 64'd0);
        check("hilo", {hi, lo}, exp_hilo);
        $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h (expect %h %h)",
                 o, a, b, hi, lo, exp_hilo[63:32], exp_hilo[31:0]);
        @(negedge clk);
        mf_req = 1'b0;
        check("done_clear", {63'd0, done}, 64'd0);
        check("no_relaunch", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        int          done_seen;
        int          busy_seen;

        reset  = 1'b1;
        start  = 1'b0;
        op     = 3'b000;
        rs_val = '0;
        rt_val = '0;
        mf_req = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        reset  = 1'b0;
        mf_req = 1'b0;

        // MTHI then MTLO on consecutive cycles, then a reserved op.
        start  = 1'b1;
        op     = 3'b100;
        rs_val = 32'h12345678;
        @(negedge clk);
        check("mthi_hi", {32'd0, hi}, 64'h12345678);
        check("mthi_lo", {32'd0, lo}, 64'd0);
        check("mthi_busy", {62'd0, busy, done}, 64'd0);
        op     = 3'b101;
        rs_val = 32'h9ABCDEF0;
        @(negedge clk);
        check("mtlo_hilo", {hi, lo}, 64'h12345678_9ABCDEF0);
        check("mtlo_busy", {62'd0, busy, done}, 64'd0);
        op     = 3'b110;
        rs_val = 32'hDEADBEEF;
        @(negedge clk);
        check("resv_hilo", {hi, lo}, 64'h12345678_9ABCDEF0);
        check("resv_busy", {62'd0, busy, done}, 64'd0);
        start = 1'b0;

        // Directed arithmetic corners.
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0);
        run_op(3'b000, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, 1'b0);
        run_op(3'b010, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b1);
        run_op(3'b011, 32'd100,      32'd0,        64'h00000064_FFFFFFFF, 1'b1);
        run_op(3'b010, 32'hFFFFFFF9, 32'd0,        64'hFFFFFFF9_FFFFFFFF, 1'b0);
        run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b1);
        run_op(3'b011, 32'd1000,     32'd7,        64'h00000006_0000008E, 1'b1);
        run_op(3'b000, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 16; i++) begin
            r_op = 3'($urandom_range(0, 3));
            r_a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            case ($urandom_range(0, 5))
                0:       r_b = 32'd0;
                1:       r_b = 32'($urandom_range(1, 20));
                2:       r_b = 32'hFFFFFFFF - 32'($urandom_range(0, 20));
                default: r_b = $urandom;
            endcase
            run_op(r_op, r_a, r_b, ref_hilo(r_op, r_a, r_b), 1'b1);
        end

        // Reset in the middle of a MULT: nothing written, no done pulse.
        @(negedge clk);
        start  = 1'b1;
        op     = 3'b100;
        rs_val = 32'hA5A5A5A5;
        @(negedge clk);
        op     = 3'b000;
        rs_val = 32'd5;
        rt_val = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        reset     = 1'b0;
        done_seen = 0;
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
            if (busy === 1'b1) busy_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);
        check("abort_no_busy", 64'(busy_seen), 64'd0);
        check("abort_hilo_hold", {hi, lo}, 64'd0);

        // Recovery after the abort.
        run_op(3'b001, 32'd3, 32'd4, 64'h00000000_0000000C, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sequences a 32-iteration shift-add / restoring-divide datapath. It raises a stall request that the hazard logic merges into PCWrite and IF/ID hold whenever the pipeline tries to use HI/LO or issue a new mul/div while an operation is in flight.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH bits each, product 2*WIDTH
CNT_W, 5, iteration counter width; log2(WIDTH)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  EX-stage mul/div-class instruction valid this cycle
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 11x reserved (ignored)
rs_val  input  WIDTH  forwarded rs operand (multiplicand / dividend / MT source)
rt_val  input  WIDTH  forwarded rt operand (multiplier / divisor)
mf_req  input  1  MFHI/MFLO present in ID stage
busy  output  1  operation in flight
stall  output  1  pipeline stall request to hazard unit
done  output  1  one-cycle pulse: HI/LO just updated by MULT/DIV
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset: state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal operand regs=0. Reset wins over every other input and aborts any in-flight op; no partial result is written.
- States: IDLE, RUN, FIX.
- IDLE, start=1, op in {000..011}:
  - Latch operands at edge E0.
  - Signed ops (MULT/DIV) latch absolute values and record sign_a=rs[31], sign_b=rt[31]. Unsigned ops take sign bits as 0.
  - counter=0, RUN, busy=1.
- IDLE, start=1, op=100/101: hi<=rs_val (MTHI) or lo<=rs_val (MTLO) at that edge. Stay IDLE; busy and done stay 0.
- IDLE, reserved op: no state change.
- RUN, one iteration per edge E1..E32:
  - Multiply: 64-bit shift-add. Add multiplicand to the upper half when product LSB is 1, then shift right.
  - Divide: restoring. Shift the remainder:quotient pair left, trial-subtract the divisor, set quotient bit when the result is non-negative.
  - counter increments; at E32 (counter==WIDTH-1) go to FIX.
- FIX, edge E33: apply sign correction, write hi/lo, return to IDLE, busy=0, done=1 for exactly the following cycle.
  - Multiply: product negated (two's complement, 64-bit) if sign_a^sign_b. hi=product[63:32], lo=product[31:0].
  - Divide: quotient negated if sign_a^sign_b; remainder takes dividend sign. lo=quotient, hi=remainder.
- busy is high for exactly 33 consecutive cycles per mul/div.
- Divide by zero (divisor==0, detected at E0): iterations still run. At FIX, lo=32'hFFFFFFFF, hi=original rs_val, with no sign correction, for DIV and DIVU alike.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out naturally from magnitude arithmetic.
- stall = busy & (start | mf_req). Combinational.
  - While busy, start is ignored; the pipeline holds the instruction via stall.
  - In IDLE, stall=0 always, including the cycle done=1. hi/lo are registered outputs, so MFHI/MFLO read the final result with no extra bubble.
- IDLE with start and mf_req both 1: start is accepted. The MF sees pre-update hi/lo that cycle, matching program order (MF older).
- Operands are sampled only at E0; later rs_val/rt_val changes have no effect.
- Arithmetic is modulo 2^64 (product) or 2^32 (quotient/remainder). No overflow flags.

Test Plan:
- reset high mid-RUN (cycle 10 of a MULT) -> next cycle busy=0, hi=lo=0, done never pulses.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> busy high exactly 33 cycles; then hi=0xFFFFFFFE, lo=0x00000001, done one-cycle pulse.
- MULT rs=0xFFFFFFFD (-3), rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU rs=100, rt=0 -> lo=0xFFFFFFFF, hi=100. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- During busy, assert mf_req and separately start (DIVU) -> stall=1 each such cycle, no second op launched, stall=0 in the done cycle. Operand changes after E0 do not alter the result.
- IDLE: MTHI rs=0x12345678 then MTLO rs=0x9ABCDEF0 on consecutive cycles -> hi/lo updated one edge later each, busy=0, done=0. MTHI with reserved op 110 -> no change.
